// File: rtl/shared_ram_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between the 6502 CPU bus and
// the video scan-out reader; video has priority, CPU wait is bounded.
module shared_ram_arbiter #(
    parameter int unsigned AW       = 16,
    parameter int unsigned DW       = 8,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset_n,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,

    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_gnt,
    output logic          vid_rvalid,
    output logic [DW-1:0] vid_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CW    = 4;
    localparam int unsigned TAG_N = RD_LAT + 1;
    localparam int unsigned RET_I = RD_LAT;

    logic [CW-1:0]    cpu_wait_q, cpu_wait_d;
    logic             mem_en_q, mem_en_d;
    logic             mem_we_q, mem_we_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
    logic [TAG_N-1:0] tag_vld_q, tag_vld_d;
    logic [TAG_N-1:0] tag_cpu_q, tag_cpu_d;
    logic             cpu_rvalid_q, cpu_rvalid_d;
    logic             vid_rvalid_q, vid_rvalid_d;
    logic [DW-1:0]    cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0]    vid_rdata_q, vid_rdata_d;

    logic             new_vld;
    logic             ret_vld;
    logic             ret_cpu;

    // Grant: video wins a tie unless the CPU has waited MAX_WAIT cycles.
    always_comb begin
        cpu_gnt = cpu_req && (!vid_req || (cpu_wait_q == CW'(MAX_WAIT)));
        vid_gnt = vid_req && !cpu_gnt;
    end

    // Starvation counter; saturating, so MAX_WAIT=0 pins it at the grant level.
    always_comb begin
        cpu_wait_d = cpu_wait_q;
        if (!cpu_req || cpu_gnt) begin
            cpu_wait_d = '0;
        end else if (cpu_wait_q != CW'(MAX_WAIT)) begin
            cpu_wait_d = cpu_wait_q + CW'(1);
        end
    end

    // Issue stage: the granted request is presented to the RAM one cycle later.
    always_comb begin
        mem_en_d    = cpu_gnt || vid_gnt;
        mem_we_d    = cpu_gnt && cpu_we;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (cpu_gnt) begin
            mem_addr_d = cpu_addr;
            if (cpu_we) begin
                mem_wdata_d = cpu_wdata;
            end
        end else if (vid_gnt) begin
            mem_addr_d = vid_addr;
        end
    end

    // Return tags travel alongside the RAM read pipeline; writes carry no tag.
    always_comb begin
        new_vld   = (cpu_gnt && !cpu_we) || vid_gnt;
        tag_vld_d = {tag_vld_q[TAG_N-2:0], new_vld};
        tag_cpu_d = {tag_cpu_q[TAG_N-2:0], cpu_gnt};
    end

    always_comb begin
        ret_vld      = tag_vld_q[RET_I];
        ret_cpu      = tag_cpu_q[RET_I];
        cpu_rvalid_d = ret_vld && ret_cpu;
        vid_rvalid_d = ret_vld && !ret_cpu;
        cpu_rdata_d  = cpu_rdata_q;
        vid_rdata_d  = vid_rdata_q;
        if (cpu_rvalid_d) begin
            cpu_rdata_d = mem_rdata;
        end
        if (vid_rvalid_d) begin
            vid_rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_wait_q   <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            tag_vld_q    <= '0;
            tag_cpu_q    <= '0;
            cpu_rvalid_q <= 1'b0;
            vid_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            vid_rdata_q  <= '0;
        end else begin
            cpu_wait_q   <= cpu_wait_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            tag_vld_q    <= tag_vld_d;
            tag_cpu_q    <= tag_cpu_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            vid_rvalid_q <= vid_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            vid_rdata_q  <= vid_rdata_d;
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign vid_rvalid = vid_rvalid_q;
    assign vid_rdata  = vid_rdata_q;

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Directed bench for shared_ram_arbiter: instance a (RD_LAT=1, MAX_WAIT=4)
// and instance b (RD_LAT=3, MAX_WAIT=0), each with its own RAM model.
module tb_shared_ram_arbiter;

    logic        clk;
    logic        reset_n;
    logic        cpu_req, cpu_we, vid_req;
    logic [15:0] cpu_addr, vid_addr;
    logic [7:0]  cpu_wdata;

    logic        cpu_gnt_a, cpu_rvalid_a, vid_gnt_a, vid_rvalid_a, mem_en_a, mem_we_a;
    logic [7:0]  cpu_rdata_a, vid_rdata_a, mem_wdata_a, mem_rdata_a;
    logic [15:0] mem_addr_a;
    logic        cpu_gnt_b, cpu_rvalid_b, vid_gnt_b, vid_rvalid_b, mem_en_b, mem_we_b;
    logic [7:0]  cpu_rdata_b, vid_rdata_b, mem_wdata_b, mem_rdata_b;
    logic [15:0] mem_addr_b;

    int nvec = 0;
    int nerr = 0;

    shared_ram_arbiter #(.AW(16), .DW(8), .RD_LAT(1), .MAX_WAIT(4)) u_a (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt_a), .cpu_rvalid(cpu_rvalid_a), .cpu_rdata(cpu_rdata_a),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_gnt(vid_gnt_a), .vid_rvalid(vid_rvalid_a), .vid_rdata(vid_rdata_a),
        .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
    );

    shared_ram_arbiter #(.AW(16), .DW(8), .RD_LAT(3), .MAX_WAIT(0)) u_b (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt_b), .cpu_rvalid(cpu_rvalid_b), .cpu_rdata(cpu_rdata_b),
        .vid_req(vid_req), .vid_addr(vid_addr),
        .vid_gnt(vid_gnt_b), .vid_rvalid(vid_rvalid_b), .vid_rdata(vid_rdata_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pre(input logic [15:0] a);
        return a[7:0] ^ 8'hC3;
    endfunction

    // Write-first RAM models, latency 1 (a) and 3 (b).
    logic [7:0] ram_a [0:65535];
    logic [7:0] ram_b [0:65535];
    logic [7:0] rd_a, rd_b0, rd_b1, rd_b2;

    always @(posedge clk) begin
        if (mem_en_a) begin
            if (mem_we_a) begin
                ram_a[mem_addr_a] <= mem_wdata_a;
                rd_a <= mem_wdata_a;
            end else begin
                rd_a <= ram_a[mem_addr_a];
            end
        end
    end

    always @(posedge clk) begin
        if (mem_en_b) begin
            if (mem_we_b) begin
                ram_b[mem_addr_b] <= mem_wdata_b;
                rd_b0 <= mem_wdata_b;
            end else begin
                rd_b0 <= ram_b[mem_addr_b];
            end
        end
        rd_b1 <= rd_b0;
        rd_b2 <= rd_b1;
    end

    assign mem_rdata_a = rd_a;
    assign mem_rdata_b = rd_b2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic creq, input logic cwe, input logic [15:0] caddr,
                         input logic [7:0] cwd, input logic vreq, input logic [15:0] vaddr);
        cpu_req   = creq;
        cpu_we    = cwe;
        cpu_addr  = caddr;
        cpu_wdata = cwd;
        vid_req   = vreq;
        vid_addr  = vaddr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0);
        end
    endtask

    // CPU write then read of one address on instance a.
    task automatic wr_rd(input string t, input logic [15:0] a, input logic [7:0] d);
        tick(); drive(1'b1, 1'b1, a, d, 1'b0, 16'h0); #1;
        chk({t, "_wr_gnt"}, 32'(cpu_gnt_a), 32'd1);
        chk({t, "_wr_vgnt"}, 32'(vid_gnt_a), 32'd0);
        tick(); drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0); #1;
        chk({t, "_wr_en"}, 32'(mem_en_a), 32'd1);
        chk({t, "_wr_we"}, 32'(mem_we_a), 32'd1);
        chk({t, "_wr_addr"}, 32'(mem_addr_a), 32'(a));
        chk({t, "_wr_data"}, 32'(mem_wdata_a), 32'(d));
        tick(); drive(1'b1, 1'b0, a, 8'h0, 1'b0, 16'h0); #1;
        chk({t, "_rd_gnt"}, 32'(cpu_gnt_a), 32'd1);
        chk({t, "_idle_en"}, 32'(mem_en_a), 32'd0);
        tick(); drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0); #1;
        chk({t, "_rd_en"}, 32'(mem_en_a), 32'd1);
        chk({t, "_rd_we"}, 32'(mem_we_a), 32'd0);
        chk({t, "_rd_addr"}, 32'(mem_addr_a), 32'(a));
        tick(); #1;
        chk({t, "_rv_early"}, 32'(cpu_rvalid_a), 32'd0);
        tick(); #1;
        chk({t, "_rv"}, 32'(cpu_rvalid_a), 32'd1);
        chk({t, "_rdata"}, 32'(cpu_rdata_a), 32'(d));
        chk({t, "_vrv"}, 32'(vid_rvalid_a), 32'd0);
        tick(); #1;
        chk({t, "_rv_pulse"}, 32'(cpu_rvalid_a), 32'd0);
        chk({t, "_rdata_hold"}, 32'(cpu_rdata_a), 32'(d));
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram_a[i] = pre(16'(i));
            ram_b[i] = pre(16'(i));
        end
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0);

        // Reset state
        tick(); #1;
        chk("rst_en", 32'(mem_en_a), 32'd0);
        chk("rst_we", 32'(mem_we_a), 32'd0);
        chk("rst_addr", 32'(mem_addr_a), 32'd0);
        chk("rst_crv", 32'(cpu_rvalid_a), 32'd0);
        chk("rst_vrv", 32'(vid_rvalid_a), 32'd0);
        chk("rst_crd", 32'(cpu_rdata_a), 32'd0);
        tick(); reset_n = 1'b1;
        idle(2);

        // Test 1: CPU-only write then read
        wr_rd("t1", 16'h0123, 8'hA5);
        idle(2);

        // Test 2: both held; a grants video 4 cycles then CPU, b always CPU
        for (int i = 0; i < 13; i++) begin
            tick();
            if (i == 0) drive(1'b1, 1'b0, 16'h0010, 8'h0, 1'b1, 16'h0020);
            if (i == 10) drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0);
            #1;
            if (i < 10) begin
                chk($sformatf("t2_cgnt_%0d", i), 32'(cpu_gnt_a), 32'((i % 5) == 4));
                chk($sformatf("t2_vgnt_%0d", i), 32'(vid_gnt_a), 32'((i % 5) != 4));
                chk($sformatf("t6_cgnt_%0d", i), 32'(cpu_gnt_b), 32'd1);
            end
            if (i >= 3) begin
                chk($sformatf("t2_crv_%0d", i), 32'(cpu_rvalid_a), 32'(((i - 3) % 5) == 4));
                chk($sformatf("t2_vrv_%0d", i), 32'(vid_rvalid_a), 32'(((i - 3) % 5) != 4));
                if (((i - 3) % 5) == 4)
                    chk($sformatf("t2_crd_%0d", i), 32'(cpu_rdata_a), 32'h0000_00D3);
                else
                    chk($sformatf("t2_vrd_%0d", i), 32'(vid_rdata_a), 32'h0000_00E3);
            end
        end
        idle(6);

        // Test 3: eight back-to-back video reads
        for (int k = 0; k < 13; k++) begin
            tick();
            if (k < 8) drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 16'(k));
            else       drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0);
            #1;
            if (k < 8) chk($sformatf("t3_vgnt_%0d", k), 32'(vid_gnt_a), 32'd1);
            if (k >= 1 && k < 9) chk($sformatf("t3_we_%0d", k), 32'(mem_we_a), 32'd0);
            chk($sformatf("t3_vrv_%0d", k), 32'(vid_rvalid_a), 32'(k >= 3 && k <= 10));
            chk($sformatf("t3_crv_%0d", k), 32'(cpu_rvalid_a), 32'd0);
            if (k >= 3 && k <= 10)
                chk($sformatf("t3_vrd_%0d", k), 32'(vid_rdata_a), 32'(pre(16'(k - 3))));
        end
        idle(4);

        // Test 4: alternating CPU/video reads on b (RD_LAT=3)
        for (int k = 0; k < 13; k++) begin
            int j;
            tick();
            if (k < 6 && (k % 2) == 0)  drive(1'b1, 1'b0, 16'(256 + k), 8'h0, 1'b0, 16'h0);
            else if (k < 6)             drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 16'(512 + k));
            else                        drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0);
            #1;
            j = k - 5;
            if (k < 6 && (k % 2) == 0) chk($sformatf("t4_cgnt_%0d", k), 32'(cpu_gnt_b), 32'd1);
            if (k < 6 && (k % 2) == 1) chk($sformatf("t4_vgnt_%0d", k), 32'(vid_gnt_b), 32'd1);
            chk($sformatf("t4_crv_%0d", k), 32'(cpu_rvalid_b), 32'(j >= 0 && j < 6 && (j % 2) == 0));
            chk($sformatf("t4_vrv_%0d", k), 32'(vid_rvalid_b), 32'(j >= 0 && j < 6 && (j % 2) == 1));
            if (j >= 0 && j < 6 && (j % 2) == 0)
                chk($sformatf("t4_crd_%0d", k), 32'(cpu_rdata_b), 32'(pre(16'(256 + j))));
            if (j >= 0 && j < 6 && (j % 2) == 1)
                chk($sformatf("t4_vrd_%0d", k), 32'(vid_rdata_b), 32'(pre(16'(512 + j))));
        end
        idle(4);

        // Test 5: reset pulse with two reads in flight on a
        tick(); drive(1'b1, 1'b0, 16'h0030, 8'h0, 1'b0, 16'h0); #1;
        chk("t5_cgnt", 32'(cpu_gnt_a), 32'd1);
        tick(); drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 16'h0031); #1;
        chk("t5_vgnt", 32'(vid_gnt_a), 32'd1);
        tick(); drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0); #1;
        chk("t5_en_pre", 32'(mem_en_a), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_en", 32'(mem_en_a), 32'd0);
        chk("t5_rst_addr", 32'(mem_addr_a), 32'd0);
        chk("t5_rst_crd", 32'(cpu_rdata_a), 32'd0);
        chk("t5_rst_vrd", 32'(vid_rdata_a), 32'd0);
        tick(); reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("t5_crv_%0d", k), 32'(cpu_rvalid_a), 32'd0);
            chk($sformatf("t5_vrv_%0d", k), 32'(vid_rvalid_a), 32'd0);
            tick();
        end
        wr_rd("t5", 16'h0040, 8'h3C);
        idle(2);

        // Test 6: CPU absolute priority on b, video only when CPU idle
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k < 4) drive(1'b1, 1'b0, 16'h0005, 8'h0, 1'b1, 16'h0006);
            else       drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 16'h0006);
            #1;
            chk($sformatf("t6b_cgnt_%0d", k), 32'(cpu_gnt_b), 32'(k < 4));
            chk($sformatf("t6b_vgnt_%0d", k), 32'(vid_gnt_b), 32'(k == 4));
        end
        idle(8);

        // Read-after-write on a: write granted N, read of same address N+1
        tick(); drive(1'b1, 1'b1, 16'h0050, 8'h77, 1'b0, 16'h0); #1;
        chk("raw_wgnt", 32'(cpu_gnt_a), 32'd1);
        tick(); drive(1'b1, 1'b0, 16'h0050, 8'h0, 1'b0, 16'h0); #1;
        chk("raw_rgnt", 32'(cpu_gnt_a), 32'd1);
        tick(); drive(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0); #1;
        chk("raw_rv2", 32'(cpu_rvalid_a), 32'd0);
        tick(); #1;
        chk("raw_rv3", 32'(cpu_rvalid_a), 32'd0);
        tick(); #1;
        chk("raw_rv4", 32'(cpu_rvalid_a), 32'd1);
        chk("raw_rdata", 32'(cpu_rdata_a), 32'h0000_0077);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
